// File: rtl/spi_master.sv
// spi_master: SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
// One DATA_W-bit full-duplex exchange per transfer. A transfer starts with a
// single-cycle start/accept handshake, and a one-cycle done pulse returns the
// received byte.
//
// Timeline, with the accept edge at cycle 0:
//   SETUP (CLK_DIV cycles), then 8 x (HIGH, LOW) half-periods, then HOLD
//   (CLK_DIV cycles). done is high in cycle 18*CLK_DIV. CE and busy release
//   one edge later.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (>= 2)
//   DATA_W   transfer width (behaviour written for 8)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             transfer request (sampled while idle)
//   tx_data, cs_sel   byte to send / chip-select choice, latched on accept
//   busy, done        transfer in progress / end-of-transfer pulse
//   rx_data           received byte, valid from done until the next done
//   SCLK, MOSI, MISO  SPI bus
//   CE0, CE1          active-low chip enables
//
// Optional feature: define SPI_MASTER_BURST_EN to accept start during the done
// cycle. The next byte then follows under the same, continuously-low CE.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cs_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CE0,
    output logic              CE1
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIV - 1);
    // A burst re-entry is accepted one edge after done. A SETUP that is one
    // cycle shorter keeps consecutive done pulses exactly 18*CLK_DIV apart.
    localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] rx_shift_r;

    // Transfer sequencer: state, half-period counter, shift registers and all
    // registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= '0;
            tx_shift_r <= '0;
            rx_shift_r <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            CE0        <= 1'b1;
            CE1        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    SCLK <= 1'b0;
                    // busy still high here means this is the done cycle.
                    // CE and busy release now, and start is not sampled.
                    if (busy) begin
`ifdef SPI_MASTER_BURST_EN
                        if (done && start) begin
                            tx_shift_r <= tx_data;
                            MOSI       <= tx_data[DATA_W-1];
                            bit_cnt_r  <= '0;
                            cnt_r      <= BURST_LOAD;
                            state_r    <= SETUP;
                        end else begin
                            MOSI <= 1'b0;
                            busy <= 1'b0;
                            CE0  <= 1'b1;
                            CE1  <= 1'b1;
                        end
`else
                        MOSI <= 1'b0;
                        busy <= 1'b0;
                        CE0  <= 1'b1;
                        CE1  <= 1'b1;
`endif
                    end else if (start) begin
                        tx_shift_r <= tx_data;
                        MOSI       <= tx_data[DATA_W-1];
                        CE0        <= cs_sel;
                        CE1        <= ~cs_sel;
                        busy       <= 1'b1;
                        bit_cnt_r  <= '0;
                        cnt_r      <= HALF_LOAD;
                        state_r    <= SETUP;
                    end else begin
                        MOSI <= 1'b0;
                        CE0  <= 1'b1;
                        CE1  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_r == '0) begin
                        SCLK       <= 1'b1;
                        rx_shift_r <= {rx_shift_r[DATA_W-2:0], MISO};
                        cnt_r      <= HALF_LOAD;
                        state_r    <= HIGH;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_r == '0) begin
                        // Zeros shift in from the bottom, so MOSI falls to 0
                        // after the last falling edge without special casing.
                        SCLK       <= 1'b0;
                        tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                        MOSI       <= tx_shift_r[DATA_W-2];
                        cnt_r      <= HALF_LOAD;
                        state_r    <= LOW;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                LOW: begin
                    if (cnt_r == '0) begin
                        cnt_r <= HALF_LOAD;
                        if (bit_cnt_r < LAST_BIT) begin
                            bit_cnt_r  <= bit_cnt_r + 1'b1;
                            SCLK       <= 1'b1;
                            rx_shift_r <= {rx_shift_r[DATA_W-2:0], MISO};
                            state_r    <= HIGH;
                        end else begin
                            state_r <= HOLD;
                        end
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_r == '0) begin
                        done    <= 1'b1;
                        rx_data <= rx_shift_r;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy    <= 1'b0;
                    SCLK    <= 1'b0;
                    MOSI    <= 1'b0;
                    CE0     <= 1'b1;
                    CE1     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
module tb_spi_master;

    localparam int CD  = 4;
    localparam int CD2 = 2;
`ifdef SPI_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cs_sel = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, sclk, mosi, miso, ce0, ce1;
    logic [7:0] rx_data;

    logic       start2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic       busy2, done2, sclk2, mosi2, ce0_2, ce1_2;
    logic [7:0] rx2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Peer model: loopback or shift a pattern out MSB first, mode 0.
    logic       loop_mode = 1'b0;
    logic [7:0] pat = 8'h00;
    logic       miso_pat = 1'b0;
    logic       prev_sclk = 1'b0;
    int         falls = 0;

    assign miso = loop_mode ? mosi : miso_pat;

    spi_master #(.CLK_DIV(CD), .DATA_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .cs_sel(cs_sel), .busy(busy), .done(done), .rx_data(rx_data),
        .SCLK(sclk), .MOSI(mosi), .MISO(miso), .CE0(ce0), .CE1(ce1)
    );

    spi_master #(.CLK_DIV(CD2), .DATA_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx2),
        .cs_sel(1'b0), .busy(busy2), .done(done2), .rx_data(rx2),
        .SCLK(sclk2), .MOSI(mosi2), .MISO(mosi2), .CE0(ce0_2), .CE1(ce1_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Peer shift-out: the next bit appears after each SCLK fall.
    always @(negedge clk) begin
        if ((ce0 && ce1) || done) begin
            falls = 0;
        end else if (prev_sclk && !sclk) begin
            falls++;
        end
        miso_pat  = (falls < 8) ? pat[7 - falls] : 1'b0;
        prev_sclk = sclk;
    end

    // Reference model: a transfer is "active" with t cycles since accept.
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_tx = 8'h00;
    logic       m_sel = 1'b0;
    logic [7:0] m_rx_exp = 8'h00;
    logic [7:0] m_rx_held = 8'h00;

    always @(posedge clk) begin
        logic e_sclk, e_mosi;
        cyc++;
        if (!rst_n) begin
            m_active  = 1'b0;
            m_t       = 0;
            m_rx_held = 8'h00;
        end else if (m_active) begin
            if (BURST && m_t == 18*CD && start) begin
                m_tx     = tx_data;
                m_rx_exp = loop_mode ? tx_data : pat;
                m_t      = 1;
            end else begin
                m_t++;
                if (m_t > 18*CD) m_active = 1'b0;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_t      = 0;
            m_tx     = tx_data;
            m_sel    = cs_sel;
            m_rx_exp = loop_mode ? tx_data : pat;
        end
        if (m_active && m_t == 18*CD) m_rx_held = m_rx_exp;
        e_sclk = m_active && m_t >= CD && m_t < 17*CD && ((m_t / CD) % 2 == 1);
        e_mosi = (m_active && m_t < 16*CD) ? m_tx[7 - m_t / (2*CD)] : 1'b0;
        #1;
        chk("busy", {7'd0, busy}, {7'd0, m_active});
        chk("done", {7'd0, done}, {7'd0, m_active && m_t == 18*CD});
        chk("sclk", {7'd0, sclk}, {7'd0, e_sclk});
        chk("mosi", {7'd0, mosi}, {7'd0, e_mosi});
        chk("ce0", {7'd0, ce0}, {7'd0, !(m_active && !m_sel)});
        chk("ce1", {7'd0, ce1}, {7'd0, !(m_active && m_sel)});
        chk("rx_data", rx_data, m_rx_held);
    end

    // One transfer on u_dut; reports latency to done, the MOSI bits seen at
    // SCLK rises, the number of rises and any cycle with a wrong CE.
    task automatic xfer(input logic [7:0] tx, input logic sel, input logic [7:0] p,
                        input logic lb, input bit pulses, output int lat,
                        output logic [7:0] bits, output int rises, output int ce_bad);
        int   guard;
        logic prevs;
        guard = 0;
        @(negedge clk);
        while ((busy || m_active) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        pat = p; loop_mode = lb; tx_data = tx; cs_sel = sel; start = 1'b1;
        @(negedge clk);
        start = 1'b0; tx_data = ~tx; cs_sel = ~sel;
        lat = 0; bits = 8'h00; rises = 0; ce_bad = 0; prevs = 1'b0;
        while (!done && lat < 400) begin
            if (sclk && !prevs) begin
                rises++;
                bits = {bits[6:0], mosi};
            end
            prevs = sclk;
            if ((sel ? ce1 : ce0) !== 1'b0 || (sel ? ce0 : ce1) !== 1'b1) ce_bad++;
            start = (pulses && (lat == 9 || lat == 70)) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("xfer_no_timeout", {7'd0, lat < 400}, 8'd1);
    endtask

    int         lat, rises, ce_bad, dcount, g;
    logic [7:0] bits;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ce", {6'd0, ce1, ce0}, 8'h03);
        chk("reset_busy", {6'd0, busy, done}, 8'h00);
        rst_n = 1'b1;

        // A5 out, 3C back, CE0
        xfer(8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0, lat, bits, rises, ce_bad);
        chk("a5_latency", lat[7:0], 8'd72);
        chk("a5_rx", rx_data, 8'h3C);
        chk("a5_mosi_bits", bits, 8'hA5);
        chk("a5_rises", rises[7:0], 8'd8);
        chk("a5_ce", ce_bad[7:0], 8'd0);

        // FF out, constant MISO=1, CE1
        xfer(8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, lat, bits, rises, ce_bad);
        chk("ff_rx", rx_data, 8'hFF);
        chk("ff_ce", ce_bad[7:0], 8'd0);

        // starts sampled at cycles 10 and 71 (and in the done cycle) are ignored
        xfer(8'h6B, 1'b0, 8'h00, 1'b0, 1'b1, lat, bits, rises, ce_bad);
        chk("busy_rx", rx_data, 8'h00);
        start = !BURST;
        @(negedge clk);
        start = 1'b0;
        chk("gap_ce_high", {6'd0, ce1, ce0}, 8'h03);
        chk("gap_busy", {7'd0, busy}, 8'h00);
        dcount = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("busy_single_done", dcount[7:0], 8'd0);

        // reset in the middle of bit 3, HIGH phase
        tx_data = 8'h5A; cs_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_reset_sclk", {7'd0, sclk}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_sclk", {7'd0, sclk}, 8'd0);
        chk("rst_ce", {6'd0, ce1, ce0}, 8'h03);
        chk("rst_busy_done", {6'd0, busy, done}, 8'h00);
        chk("rst_rx", rx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("rst_no_done", dcount[7:0], 8'd0);

        // loopback on the CLK_DIV=2 instance
        tx2 = 8'h81; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; tx2 = 8'h00;
        lat = 0;
        while (!done2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("lb_latency", lat[7:0], 8'd36);
        chk("lb_rx", rx2, 8'h81);

`ifdef SPI_MASTER_BURST_EN
        // burst: 12 then 34 under one CE0
        xfer(8'h12, 1'b0, 8'h00, 1'b1, 1'b0, lat, bits, rises, ce_bad);
        chk("burst_rx0", rx_data, 8'h12);
        tx_data = 8'h34; cs_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; ce_bad = 0;
        while (!done && lat < 400) begin
            if (ce0 !== 1'b0) ce_bad++;
            @(negedge clk);
            lat++;
        end
        chk("burst_gap", lat[7:0], 8'(18*CD));
        chk("burst_ce0_low", ce_bad[7:0], 8'd0);
        chk("burst_rx1", rx_data, 8'h34);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            tx_data = 8'($urandom);
            cs_sel  = 1'($urandom);
            start   = ($urandom_range(0, 19) == 0);
            if (!m_active && !busy) begin
                pat       = 8'($urandom);
                loop_mode = 1'($urandom);
            end
        end
        start = 1'b0;
        g = 0;
        while ((busy || m_active) && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("final_idle", {7'd0, busy}, 8'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first). Generates SCLK, MOSI, CE0 and CE1 from the system clock, and samples MISO.
- Drives the board-level SPI slave used on the icestick: a bench or host-side peer, or a second FPGA block talking to the existing slave.
- Each transfer is one 8-bit full-duplex exchange, started by a single-cycle handshake. A done pulse returns the received byte.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles. Legal range is ≥2. Use ≥4 when the peer is the team's oversampling slave.
- DATA_W, 8: transfer width in bits. Behaviour below is written for 8.

Ports:
- clk  input  1  system clock (48 MHz); all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a transfer; sampled only when busy=0, or under the optional feature
- tx_data  input  DATA_W  byte to send; latched on the accept edge
- cs_sel  input  1  0 = assert CE0, 1 = assert CE1; latched on the accept edge
- busy  output  1  high from the accept edge until the cycle after done
- done  output  1  one-cycle pulse at the end of a transfer
- rx_data  output  DATA_W  received byte; valid from done, held until the next done
- SCLK  output  1  SPI clock; idle low
- MOSI  output  1  master out
- MISO  input  1  master in
- CE0  output  1  chip enable 0, active low
- CE1  output  1  chip enable 1, active low

Behaviour:
- Reset (async, any time, including mid-transfer):
  - SCLK=0, MOSI=0, CE0=1, CE1=1, busy=0, done=0, rx_data=0, state IDLE, counters 0.
  - A transfer interrupted by reset is lost; there is no done pulse.
- States and transitions:
  - IDLE: outputs inactive. start=1 → latch tx_data into tx_shift and cs_sel; go to SETUP; busy=1.
  - SETUP:
    - Selected CE low, MOSI=tx_shift[7], SCLK=0.
    - Held CLK_DIV cycles, then go to HIGH.
  - HIGH:
    - SCLK=1.
    - On entry edge: rx_shift ← {rx_shift[6:0], MISO}.
    - Held CLK_DIV cycles, then go to LOW.
  - LOW:
    - SCLK=0.
    - On entry edge: tx_shift shifts left by one; MOSI takes the next bit.
    - Held CLK_DIV cycles. If bit_cnt<7, increment bit_cnt and go to HIGH; else go to HOLD.
    - After the 8th falling edge MOSI holds 0.
  - HOLD:
    - CE remains low for CLK_DIV cycles. done=1 in the last HOLD cycle; rx_data ← rx_shift on that edge.
    - Next state is IDLE. CE deasserts and busy drops on the following edge.
- Timing:
  - With the accept edge at cycle 0, done is high at cycle 18·CLK_DIV. For CLK_DIV=4, that is cycle 72.
  - CE is high for at least 1 cycle between non-burst transfers.
- Handshake and boundaries:
  - start while busy=1 is ignored, including the done cycle, unless the optional feature is compiled in.
  - tx_data and cs_sel changes after the accept edge have no effect on the transfer.
  - Only one CE is ever low. Both CEs are high in IDLE.
  - A MISO held constant for the whole transfer gives rx_data=8'h00 or 8'hFF.
  - The half-period counter is a free-running down-counter reloaded on every state entry; it does not wrap across states.

Optional Feature:
- Macro SPI_MASTER_BURST_EN.
- Defined:
  - start=1 in the done cycle is accepted: tx_data is latched and the next state is SETUP, not IDLE.
  - CE stays low continuously; cs_sel is ignored and the current CE is kept. busy stays high.
  - This gives multi-byte frames under a single CE.
- Undefined: start in the done cycle is ignored, and CE always deasserts between transfers.

Test Plan:
- Reset: assert rst_n=0 mid-transfer (bit 3, HIGH) → same cycle SCLK=0, CE0=CE1=1, busy=0, done=0, rx_data=0. No done follows.
- Single transfer, CLK_DIV=4, cs_sel=0, tx_data=8'hA5, MISO model returning 8'h3C → MOSI bits 1,0,1,0,0,1,0,1 at each SCLK rise. Exactly 8 SCLK pulses of 4 cycles high and 4 low. CE0 low, CE1 high throughout. done at cycle 72 with rx_data=8'h3C.
- cs_sel=1, tx_data=8'hFF, MISO=1 constant → only CE1 asserts; rx_data=8'hFF.
- start pulsed at cycles 10 and 71 during a busy transfer → both ignored; exactly one done; CE high for ≥1 cycle after.
- Loopback MOSI→MISO with tx_data=8'h81 and CLK_DIV=2 → rx_data=8'h81; done at cycle 36.
- SPI_MASTER_BURST_EN: start in the done cycle with 8'h12, then 8'h34 → CE0 never rises between bytes. Two done pulses 18·CLK_DIV apart; the peer receives 8'h12, 8'h34.
